// File: rtl/fp32_pkg.sv
// Shared FP32 field definitions, operand classification and checker state
// encoding for the adder result checker.
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;

   localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
   localparam logic [31:0]      POS_ZERO  = 32'h0000_0000;
   localparam logic [31:0]      NEG_ZERO  = 32'h8000_0000;
   localparam logic [31:0]      SIGN_MASK = 32'h8000_0000;

   typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_e;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_e;

   function automatic fp_class_e fp32_class(input logic [31:0] v);
      logic [EXP_W-1:0]  e;
      logic [MANT_W-1:0] m;
      e = v[30:23];
      m = v[22:0];
      if (e == EXP_MAX) return (m != '0) ? NAN : INF;
      if (e == '0)      return (m != '0) ? DENORM : ZERO;
      return NORMAL;
   endfunction

endpackage

// File: rtl/fp32_result_checker_if.sv
// Stimulus/result bus shared by the FP32 adder and its result checker.
interface fp32_result_checker_if;

   logic [31:0] x1;
   logic [31:0] x2;
   logic        val;
   logic        over;
   logic [31:0] y;

   // Stimulus source together with the adder output it feeds.
   modport master (output x1, output x2, output val, output over, output y);

   modport slave  (input x1, input x2, input val, input over, input y);

endinterface

// File: rtl/fp32_delay_line.sv
// Fixed-depth shift register, cleared by asynchronous reset, shifting every cycle.
module fp32_delay_line #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] line_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      end else begin
         line_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
      end
   end

   assign dout_o = line_q[DEPTH-1];

endmodule

// File: rtl/fp32_result_checker.sv
// Result sink for the FP32 adder bench: aligns operands with y, applies
// IEEE-754 sanity rules, keeps saturating counts and captures the first failure.
module fp32_result_checker
   import fp32_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   fp32_result_checker_if.slave bus,
   output logic [CNT_W-1:0]     chk_cnt,
   output logic [CNT_W-1:0]     pass_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 err_pulse,
   output logic [31:0]          first_x1,
   output logic [31:0]          first_x2,
   output logic [31:0]          first_y,
   output logic                 first_vld,
   output logic                 done
);

   localparam int LINE_W = 65;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   chk_state_e state_q, state_d;
   logic [3:0] drain_q, drain_d;

   logic [LINE_W-1:0] line_in, line_out;
   logic              t_vld;
   logic [31:0]       t_x1, t_x2;

   logic [CNT_W-1:0] chk_q, chk_d, pass_q, pass_d, err_q, err_d;
   logic             pulse_q, pulse_d;
   logic [31:0]      fx1_q, fx1_d, fx2_q, fx2_d, fy_q, fy_d;
   logic             fvld_q, fvld_d;

   fp_class_e c1, c2, cy;
   logic      skip, ok, chk_hit, fail;

   always_comb begin
      state_d = state_q;
      drain_d = '0;
      case (state_q)
         IDLE:    if (bus.over) state_d = DRAIN;
                  else if (bus.val) state_d = RUN;
         RUN:     if (bus.over) state_d = DRAIN;
         DRAIN: begin
            drain_d = drain_q + 4'd1;
            if (drain_q == 4'(LATENCY - 1)) state_d = DONE;
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // The cycle over first rises still sees IDLE/RUN, so that vector enters the line.
   assign line_in = (state_q == IDLE || state_q == RUN) ?
                    {bus.val, bus.x1, bus.x2} : '0;

   fp32_delay_line #(
      .DEPTH (LATENCY),
      .WIDTH (LINE_W)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .din_i  (line_in),
      .dout_o (line_out)
   );

   assign t_vld = line_out[64];
   assign t_x1  = line_out[63:32];
   assign t_x2  = line_out[31:0];

   always_comb begin
      c1   = fp32_class(t_x1);
      c2   = fp32_class(t_x2);
      cy   = fp32_class(bus.y);
      skip = 1'b0;
      ok   = 1'b1;
      if (c1 == NAN || c2 == NAN)
         ok = (cy == NAN);
      else if (c1 == INF && c2 == INF && (t_x1[31] != t_x2[31]))
         ok = (cy == NAN);
      else if (c1 == INF)
         ok = (bus.y == t_x1);
      else if (c2 == INF)
         ok = (bus.y == t_x2);
      else if (c1 == ZERO && c2 == ZERO)
         ok = (bus.y == ((t_x1[31] & t_x2[31]) ? NEG_ZERO : POS_ZERO));
      else if (c1 == ZERO && c2 == NORMAL)
         ok = (bus.y == t_x2);
      else if (c2 == ZERO && c1 == NORMAL)
         ok = (bus.y == t_x1);
      else if ((t_x2 == (t_x1 ^ SIGN_MASK)) && (c1 == NORMAL || c1 == DENORM))
         ok = (bus.y == POS_ZERO);
      else if (c1 == DENORM || c2 == DENORM)
         skip = 1'b1;
      else
         ok = (cy != NAN);
      chk_hit = t_vld && !skip;
      fail    = chk_hit && !ok;
   end

   always_comb begin
      chk_d   = chk_q;
      pass_d  = pass_q;
      err_d   = err_q;
      pulse_d = fail;
      fx1_d   = fx1_q;
      fx2_d   = fx2_q;
      fy_d    = fy_q;
      fvld_d  = fvld_q;
      if (chk_hit) begin
         chk_d = sat_inc(chk_q);
         if (fail) err_d  = sat_inc(err_q);
         else      pass_d = sat_inc(pass_q);
      end
      if (fail && !fvld_q) begin
         fx1_d  = t_x1;
         fx2_d  = t_x2;
         fy_d   = bus.y;
         fvld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q   <= '0;
         pass_q  <= '0;
         err_q   <= '0;
         pulse_q <= 1'b0;
         fx1_q   <= '0;
         fx2_q   <= '0;
         fy_q    <= '0;
         fvld_q  <= 1'b0;
      end else begin
         chk_q   <= chk_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         pulse_q <= pulse_d;
         fx1_q   <= fx1_d;
         fx2_q   <= fx2_d;
         fy_q    <= fy_d;
         fvld_q  <= fvld_d;
      end
   end

   assign chk_cnt   = chk_q;
   assign pass_cnt  = pass_q;
   assign err_cnt   = err_q;
   assign err_pulse = pulse_q;
   assign first_x1  = fx1_q;
   assign first_x2  = fx2_q;
   assign first_y   = fy_q;
   assign first_vld = fvld_q;
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_fp32_result_checker.sv
// Directed bench for fp32_result_checker with a 3-stage pass-through model adder.
module tb_fp32_result_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] chk_cnt, pass_cnt, err_cnt;
   logic        err_pulse, first_vld, done;
   logic [31:0] first_x1, first_x2, first_y;

   logic [31:0] ysum = '0;
   logic [31:0] y_p0 = '0, y_p1 = '0, y_p2 = '0;

   int n_cmp = 0;
   int n_bad = 0;

   fp32_result_checker_if bus ();

   fp32_result_checker #(.LATENCY(3), .CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .chk_cnt   (chk_cnt),
      .pass_cnt  (pass_cnt),
      .err_cnt   (err_cnt),
      .err_pulse (err_pulse),
      .first_x1  (first_x1),
      .first_x2  (first_x2),
      .first_y   (first_y),
      .first_vld (first_vld),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Model adder: returns the result supplied with each vector, 3 cycles later.
   always @(posedge clk) begin
      y_p0 <= ysum;
      y_p1 <= y_p0;
      y_p2 <= y_p1;
   end
   assign bus.y = y_p2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
      bus.x1  = a;
      bus.x2  = b;
      bus.val = 1'b1;
      ysum    = r;
      tick();
      bus.val = 1'b0;
      bus.x1  = '0;
      bus.x2  = '0;
      ysum    = '0;
   endtask

   initial begin
      rst      = 1'b1;
      bus.x1   = '0;
      bus.x2   = '0;
      bus.val  = 1'b0;
      bus.over = 1'b0;
      tick();
      tick();
      chk("rst_chk",   chk_cnt,   32'd0);
      chk("rst_pass",  pass_cnt,  32'd0);
      chk("rst_err",   err_cnt,   32'd0);
      chk("rst_pulse", err_pulse, 32'd0);
      chk("rst_fvld",  first_vld, 32'd0);
      chk("rst_done",  done,      32'd0);
      rst = 1'b0;
      tick();

      // 1.0 + 1.0 = 2.0, generic rule, pass
      send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
      tick(); tick();
      chk("add11_early", chk_cnt, 32'd0);
      tick();
      chk("add11_chk",   chk_cnt,   32'd1);
      chk("add11_pass",  pass_cnt,  32'd1);
      chk("add11_pulse", err_pulse, 32'd0);

      // NaN + 1.0 with faulty result 1.0: strobe lands 4 cycles after val
      send(32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000);
      tick(); tick();
      chk("nan_pulse_early", err_pulse, 32'd0);
      tick();
      chk("nan_pulse", err_pulse, 32'd1);
      chk("nan_err",   err_cnt,   32'd1);
      chk("nan_chk",   chk_cnt,   32'd2);
      chk("nan_fvld",  first_vld, 32'd1);
      chk("nan_fx1",   first_x1,  32'h7FC0_0000);
      chk("nan_fx2",   first_x2,  32'h3F80_0000);
      chk("nan_fy",    first_y,   32'h3F80_0000);
      tick();
      chk("nan_pulse_end", err_pulse, 32'd0);

      // Special-value batch, back to back; the 1.0+0 vector carries a wrong result
      send(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
      send(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      send(32'h40A0_0000, 32'hC0A0_0000, 32'h0000_0000);
      send(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0001);
      send(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
      tick(); tick(); tick();
      chk("spec_chk",  chk_cnt,  32'd7);
      chk("spec_pass", pass_cnt, 32'd5);
      chk("spec_err",  err_cnt,  32'd2);
      chk("spec_fx1_kept", first_x1, 32'h7FC0_0000);
      chk("spec_fy_kept",  first_y,  32'h3F80_0000);

      // Denormal operand: not checked at all
      send(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
      tick(); tick(); tick();
      chk("denorm_chk",   chk_cnt,   32'd7);
      chk("denorm_pulse", err_pulse, 32'd0);

      // Ten vectors at full rate, over on the tenth
      for (int i = 0; i < 9; i++) send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
      bus.over = 1'b1;
      send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
      chk("b2b_done_1", done, 32'd0);
      tick(); tick();
      chk("b2b_done_3", done, 32'd0);
      tick();
      chk("b2b_done_4", done,     32'd1);
      chk("b2b_chk",    chk_cnt,  32'd17);
      chk("b2b_pass",   pass_cnt, 32'd15);
      chk("b2b_err",    err_cnt,  32'd2);
      send(32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000);
      tick(); tick(); tick(); tick();
      chk("done_ign_chk", chk_cnt, 32'd17);
      chk("done_sticky",  done,    32'd1);

      // Mid-stream reset discards in-flight vectors
      rst = 1'b1;
      bus.over = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
      tick(); tick(); tick();
      chk("pre_rst_chk", chk_cnt, 32'd1);
      send(32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000);
      send(32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000);
      rst = 1'b1;
      tick();
      chk("mrst_chk",  chk_cnt,   32'd0);
      chk("mrst_pass", pass_cnt,  32'd0);
      chk("mrst_done", done,      32'd0);
      chk("mrst_fvld", first_vld, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mrst_pulse", err_pulse, 32'd0);
      end
      chk("mrst_err_after", err_cnt, 32'd0);
      chk("mrst_chk_after", chk_cnt, 32'd0);
      chk("mrst_fx1_after", first_x1, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
